// File: rtl/wb_ex_commit_pkg.sv
// Shared definitions for the WB-stage exception/ERET commit controller:
// exception codes, CP0 register numbers, flag bit positions and FSM states.
package wb_ex_commit_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [31:0] EX_VECTOR_DEFAULT = 32'hBFC00380;

  localparam int EX_FLAGS_W  = 7;
  localparam int FLG_ADEL_IF = 0;
  localparam int FLG_RI      = 1;
  localparam int FLG_OV      = 2;
  localparam int FLG_SYS     = 3;
  localparam int FLG_BP      = 4;
  localparam int FLG_ADEL_LD = 5;
  localparam int FLG_ADES_ST = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } state_e;

endpackage

// File: rtl/ex_prio_enc.sv
// Combinational priority encoder: picks the single exception code that the
// retiring instruction commits, with a pending interrupt beating every flag.
module ex_prio_enc
  import wb_ex_commit_pkg::*;
(
  input  logic [EX_FLAGS_W-1:0] flags,
  input  logic                  int_pending,
  output logic [4:0]            code,
  output logic                  is_ex,
  output logic                  is_if_err
);

  always_comb begin
    code      = EXC_INT;
    is_if_err = 1'b0;
    is_ex     = int_pending | (|flags);
    if (int_pending) begin
      code = EXC_INT;
    end else if (flags[FLG_ADEL_IF]) begin
      code      = EXC_ADEL;
      is_if_err = 1'b1;
    end else if (flags[FLG_RI]) begin
      code = EXC_RI;
    end else if (flags[FLG_OV]) begin
      code = EXC_OV;
    end else if (flags[FLG_SYS]) begin
      code = EXC_SYS;
    end else if (flags[FLG_BP]) begin
      code = EXC_BP;
    end else if (flags[FLG_ADEL_LD]) begin
      code = EXC_ADEL;
    end else if (flags[FLG_ADES_ST]) begin
      code = EXC_ADES;
    end
  end

endmodule

// File: rtl/wb_ex_commit.sv
// WB-stage exception/ERET commit controller: registers one-cycle CP0 strobes,
// then flushes the pipeline and holds a fetch redirect until it is accepted.
module wb_ex_commit
  import wb_ex_commit_pkg::*;
#(
  parameter logic [31:0] EX_VECTOR = EX_VECTOR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [31:0]           wb_pc,
  input  logic                  wb_bd,
  input  logic [EX_FLAGS_W-1:0] wb_ex_flags,
  input  logic [31:0]           wb_data_vaddr,
  input  logic                  wb_eret,
  input  logic                  wb_mtc0,
  input  logic [4:0]            wb_mtc0_addr,
  input  logic [31:0]           wb_mtc0_data,
  input  logic                  int_pending,
  input  logic [31:0]           cp0_epc,
  output logic [4:0]            ex_code,
  output logic                  ex_bd,
  output logic [31:0]           ex_pc,
  output logic [31:0]           ex_badvaddr,
  output logic                  ex_pc_error,
  output logic                  cp0_eret,
  output logic                  cp0_mtc0,
  output logic [4:0]            cp0_mtc0_addr,
  output logic [31:0]           cp0_mtc0_data,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  input  logic                  redirect_ready
);

  logic [4:0]  prio_code;
  logic        prio_is_ex;
  logic        prio_is_if_err;
  logic        trigger;
  logic        mtc0_fire;
  logic        data_fault;
  logic [31:0] badvaddr_d;

  state_e      state_q;
  logic        is_ex_q;
  logic [4:0]  ex_code_q;
  logic        ex_bd_q;
  logic [31:0] ex_pc_q;
  logic [31:0] ex_badvaddr_q;
  logic        ex_pc_error_q;
  logic        cp0_eret_q;
  logic        cp0_mtc0_q;
  logic [4:0]  cp0_mtc0_addr_q;
  logic [31:0] cp0_mtc0_data_q;
  logic        flush_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  ex_prio_enc u_prio (
    .flags       (wb_ex_flags),
    .int_pending (int_pending),
    .code        (prio_code),
    .is_ex       (prio_is_ex),
    .is_if_err   (prio_is_if_err)
  );

  // BadVAddr only carries an address for the two data-side faults and fetch AdEL.
  always_comb begin
    trigger    = wb_valid & (int_pending | (|wb_ex_flags) | wb_eret);
    mtc0_fire  = wb_mtc0 & ~trigger;
    data_fault = ~int_pending & ~(|wb_ex_flags[FLG_BP:FLG_ADEL_IF])
               & (wb_ex_flags[FLG_ADEL_LD] | wb_ex_flags[FLG_ADES_ST]);
    badvaddr_d = prio_is_if_err ? wb_pc : (data_fault ? wb_data_vaddr : 32'h0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      is_ex_q          <= 1'b0;
      ex_code_q        <= '0;
      ex_bd_q          <= 1'b0;
      ex_pc_q          <= '0;
      ex_badvaddr_q    <= '0;
      ex_pc_error_q    <= 1'b0;
      cp0_eret_q       <= 1'b0;
      cp0_mtc0_q       <= 1'b0;
      cp0_mtc0_addr_q  <= '0;
      cp0_mtc0_data_q  <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ex_code_q       <= '0;
          ex_bd_q         <= 1'b0;
          ex_pc_q         <= '0;
          ex_badvaddr_q   <= '0;
          ex_pc_error_q   <= 1'b0;
          cp0_eret_q      <= 1'b0;
          cp0_mtc0_q      <= mtc0_fire;
          cp0_mtc0_addr_q <= mtc0_fire ? wb_mtc0_addr : 5'h0;
          cp0_mtc0_data_q <= mtc0_fire ? wb_mtc0_data : 32'h0;
          flush_q         <= 1'b0;
          if (trigger) begin
            state_q    <= COMMIT;
            is_ex_q    <= prio_is_ex;
            flush_q    <= 1'b1;
            cp0_eret_q <= ~prio_is_ex;
            if (prio_is_ex) begin
              ex_code_q     <= prio_code;
              ex_bd_q       <= wb_bd;
              ex_pc_q       <= wb_pc;
              ex_badvaddr_q <= badvaddr_d;
              ex_pc_error_q <= prio_is_if_err;
            end
          end
        end
        // EPC is sampled here so an MTC0 retired just before the ERET is seen.
        COMMIT: begin
          ex_code_q        <= '0;
          ex_bd_q          <= 1'b0;
          ex_pc_q          <= '0;
          ex_badvaddr_q    <= '0;
          ex_pc_error_q    <= 1'b0;
          cp0_eret_q       <= 1'b0;
          cp0_mtc0_q       <= 1'b0;
          flush_q          <= 1'b1;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= is_ex_q ? EX_VECTOR : cp0_epc;
          state_q          <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_code        = ex_code_q;
  assign ex_bd          = ex_bd_q;
  assign ex_pc          = ex_pc_q;
  assign ex_badvaddr    = ex_badvaddr_q;
  assign ex_pc_error    = ex_pc_error_q;
  assign cp0_eret       = cp0_eret_q;
  assign cp0_mtc0       = cp0_mtc0_q;
  assign cp0_mtc0_addr  = cp0_mtc0_addr_q;
  assign cp0_mtc0_data  = cp0_mtc0_data_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_wb_ex_commit.sv
// Bench for wb_ex_commit: directed scenarios plus randomized traffic checked
// against a transaction-level reference model and a small CP0 EPC model.
module tb_wb_ex_commit;

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam logic [4:0] CODE_TAB [7] = '{5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05};

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_bd, wb_eret, wb_mtc0, int_pending, redirect_ready;
  logic [31:0] wb_pc, wb_data_vaddr, wb_mtc0_data, cp0_epc;
  logic [6:0]  wb_ex_flags;
  logic [4:0]  wb_mtc0_addr;
  logic [4:0]  ex_code, cp0_mtc0_addr;
  logic        ex_bd, ex_pc_error, cp0_eret, cp0_mtc0, flush, redirect_valid;
  logic [31:0] ex_pc, ex_badvaddr, cp0_mtc0_data, redirect_pc;

  typedef struct packed {
    logic [4:0]  code;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] bva;
    logic        pe;
    logic        eret;
    logic        mtc0;
    logic [4:0]  maddr;
    logic [31:0] mdata;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
  } out_t;

  out_t        act_o, exp_o;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          m_phase = 0;
  logic        m_isex = 1'b0;
  logic [31:0] m_rpc = 32'h0;
  logic [31:0] epc_q;

  wb_ex_commit dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_bd(wb_bd),
    .wb_ex_flags(wb_ex_flags), .wb_data_vaddr(wb_data_vaddr), .wb_eret(wb_eret),
    .wb_mtc0(wb_mtc0), .wb_mtc0_addr(wb_mtc0_addr), .wb_mtc0_data(wb_mtc0_data),
    .int_pending(int_pending), .cp0_epc(cp0_epc), .ex_code(ex_code), .ex_bd(ex_bd),
    .ex_pc(ex_pc), .ex_badvaddr(ex_badvaddr), .ex_pc_error(ex_pc_error),
    .cp0_eret(cp0_eret), .cp0_mtc0(cp0_mtc0), .cp0_mtc0_addr(cp0_mtc0_addr),
    .cp0_mtc0_data(cp0_mtc0_data), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  // CP0 stand-in: only the EPC register, written by the MTC0 strobe.
  always @(posedge clk) begin
    if (reset) epc_q <= 32'h0;
    else if (cp0_mtc0 && cp0_mtc0_addr == 5'd14) epc_q <= cp0_mtc0_data;
  end
  assign cp0_epc = epc_q;

  assign act_o = {ex_code, ex_bd, ex_pc, ex_badvaddr, ex_pc_error, cp0_eret, cp0_mtc0,
                  cp0_mtc0_addr, cp0_mtc0_data, flush, redirect_valid, redirect_pc};

  // Reference: what the outputs must show after the coming clock edge.
  task automatic model_step();
    int src;
    exp_o = '0;
    if (reset) begin
      m_phase = 0;
      return;
    end
    if (m_phase == 0) begin
      if (wb_valid && (int_pending || wb_ex_flags != 0 || wb_eret)) begin
        m_isex = int_pending || (wb_ex_flags != 0);
        exp_o.flush = 1'b1;
        m_phase = 1;
        if (m_isex) begin
          src = -1;
          if (!int_pending)
            for (int i = 6; i >= 0; i--) if (wb_ex_flags[i]) src = i;
          exp_o.code = (src < 0) ? 5'h00 : CODE_TAB[src];
          exp_o.bd   = wb_bd;
          exp_o.pc   = wb_pc;
          exp_o.pe   = (src == 0);
          exp_o.bva  = (src == 0) ? wb_pc : ((src == 5 || src == 6) ? wb_data_vaddr : 32'h0);
        end else begin
          exp_o.eret = 1'b1;
        end
      end else if (wb_mtc0) begin
        exp_o.mtc0  = 1'b1;
        exp_o.maddr = wb_mtc0_addr;
        exp_o.mdata = wb_mtc0_data;
      end
    end else if (m_phase == 1) begin
      m_rpc = m_isex ? VEC : cp0_epc;
      exp_o.flush = 1'b1;
      exp_o.rv = 1'b1;
      exp_o.rpc = m_rpc;
      m_phase = 2;
    end else begin
      if (redirect_ready) begin
        m_phase = 0;
      end else begin
        exp_o.flush = 1'b1;
        exp_o.rv = 1'b1;
        exp_o.rpc = m_rpc;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    wb_valid = 0; wb_pc = 0; wb_bd = 0; wb_ex_flags = 0; wb_data_vaddr = 0;
    wb_eret = 0; wb_mtc0 = 0; wb_mtc0_addr = 0; wb_mtc0_data = 0;
    int_pending = 0; redirect_ready = 0;
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1;
    step();
    n_cmp++;
    if (act_o !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", act_o); end
    reset = 0;
    step();
    n_cmp++;
    if (act_o !== '0) begin n_fail++; $display("FAIL idle_outputs: got %h want 0", act_o); end
  endtask

  task automatic test_ov();
    clear_in();
    wb_valid = 1; wb_pc = 32'h80001000; wb_ex_flags = 7'b0000100; wb_data_vaddr = 32'h55aa;
    step();
    clear_in();
    n_cmp++;
    if ({ex_code, ex_pc, ex_pc_error, ex_bd, flush, ex_badvaddr} !== {5'h0c, 32'h80001000, 1'b0, 1'b0, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL ov_commit: got code=%h pc=%h pe=%b bd=%b fl=%b bva=%h want 0c 80001000 0 0 1 0",
                         ex_code, ex_pc, ex_pc_error, ex_bd, flush, ex_badvaddr);
    end
    redirect_ready = 1;
    step();
    n_cmp++;
    if ({redirect_valid, flush, redirect_pc, ex_code} !== {1'b1, 1'b1, VEC, 5'h0}) begin
      n_fail++; $display("FAIL ov_redirect: got rv=%b fl=%b rpc=%h code=%h want 1 1 %h 0", redirect_valid, flush, redirect_pc, ex_code, VEC);
    end
    step();
    n_cmp++;
    if ({redirect_valid, flush} !== 2'b00) begin n_fail++; $display("FAIL ov_done: got rv=%b fl=%b want 0 0", redirect_valid, flush); end
  endtask

  task automatic test_adel_if();
    clear_in();
    wb_valid = 1; wb_pc = 32'h80000003; wb_bd = 1; wb_ex_flags = 7'b0000001; wb_data_vaddr = 32'h1234;
    step();
    clear_in();
    n_cmp++;
    if ({ex_code, ex_pc_error, ex_badvaddr, ex_bd, ex_pc} !== {5'h04, 1'b1, 32'h80000003, 1'b1, 32'h80000003}) begin
      n_fail++; $display("FAIL adel_if: got code=%h pe=%b bva=%h bd=%b pc=%h want 04 1 80000003 1 80000003",
                         ex_code, ex_pc_error, ex_badvaddr, ex_bd, ex_pc);
    end
    redirect_ready = 1;
    step();
    step();
  endtask

  task automatic test_priority();
    logic [6:0]  fl [4] = '{7'b1000010, 7'b1000000, 7'b0110000, 7'b0011000};
    logic [4:0]  code_w [4] = '{5'h0a, 5'h05, 5'h09, 5'h08};
    logic [31:0] bva_w [4] = '{32'h0, 32'h1002, 32'h0, 32'h0};
    for (int k = 0; k < 4; k++) begin
      clear_in();
      wb_valid = 1; wb_pc = 32'h80004000 + 32'(k * 4); wb_ex_flags = fl[k]; wb_data_vaddr = 32'h1002;
      step();
      clear_in();
      n_cmp++;
      if ({ex_code, ex_badvaddr, ex_pc_error} !== {code_w[k], bva_w[k], 1'b0}) begin
        n_fail++; $display("FAIL prio_%0d: got code=%h bva=%h pe=%b want %h %h 0", k, ex_code, ex_badvaddr, ex_pc_error, code_w[k], bva_w[k]);
      end
      redirect_ready = 1;
      step();
      step();
    end
  endtask

  task automatic test_mtc0_eret();
    clear_in();
    wb_valid = 1; wb_mtc0 = 1; wb_mtc0_addr = 5'd14; wb_mtc0_data = 32'h80002000;
    step();
    clear_in();
    wb_valid = 1; wb_eret = 1;
    n_cmp++;
    if ({cp0_mtc0, cp0_mtc0_addr, cp0_mtc0_data, flush} !== {1'b1, 5'd14, 32'h80002000, 1'b0}) begin
      n_fail++; $display("FAIL mtc0_pulse: got m=%b a=%h d=%h fl=%b want 1 0e 80002000 0", cp0_mtc0, cp0_mtc0_addr, cp0_mtc0_data, flush);
    end
    step();
    clear_in();
    redirect_ready = 1;
    n_cmp++;
    if ({cp0_eret, ex_code, cp0_mtc0, flush} !== {1'b1, 5'h0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL eret_pulse: got eret=%b code=%h m=%b fl=%b want 1 0 0 1", cp0_eret, ex_code, cp0_mtc0, flush);
    end
    step();
    n_cmp++;
    if ({redirect_valid, redirect_pc, cp0_eret} !== {1'b1, 32'h80002000, 1'b0}) begin
      n_fail++; $display("FAIL eret_redirect: got rv=%b rpc=%h eret=%b want 1 80002000 0", redirect_valid, redirect_pc, cp0_eret);
    end
    step();
  endtask

  task automatic test_stall();
    clear_in();
    wb_valid = 1; wb_pc = 32'h80003000; wb_ex_flags = 7'b0001000;
    step();
    for (int c = 0; c < 6; c++) begin
      wb_valid = 1; wb_ex_flags = 7'($urandom); wb_eret = 1; wb_mtc0 = 1;
      wb_mtc0_addr = 5'd14; wb_mtc0_data = $urandom; int_pending = 1'($urandom);
      redirect_ready = 0;
      step();
      n_cmp++;
      if ({flush, redirect_valid, redirect_pc, cp0_mtc0, cp0_eret, ex_code} !== {1'b1, 1'b1, VEC, 1'b0, 1'b0, 5'h0}) begin
        n_fail++; $display("FAIL stall_hold_%0d: got fl=%b rv=%b rpc=%h m=%b e=%b code=%h want 1 1 %h 0 0 0",
                           c, flush, redirect_valid, redirect_pc, cp0_mtc0, cp0_eret, ex_code, VEC);
      end
    end
    redirect_ready = 1;
    step();
    n_cmp++;
    if ({flush, redirect_valid, cp0_mtc0, cp0_eret, ex_code} !== 9'h0) begin
      n_fail++; $display("FAIL stall_release: got fl=%b rv=%b m=%b e=%b code=%h want all 0", flush, redirect_valid, cp0_mtc0, cp0_eret, ex_code);
    end
    clear_in();
    step();
  endtask

  task automatic test_int_override();
    clear_in();
    wb_valid = 1; wb_pc = 32'h80005004; int_pending = 1; wb_eret = 1; wb_mtc0 = 1;
    wb_mtc0_addr = 5'd14; wb_mtc0_data = 32'hdeadbeef;
    step();
    clear_in();
    n_cmp++;
    if ({ex_code, cp0_eret, cp0_mtc0, flush, ex_pc} !== {5'h00, 1'b0, 1'b0, 1'b1, 32'h80005004}) begin
      n_fail++; $display("FAIL int_commit: got code=%h e=%b m=%b fl=%b pc=%h want 00 0 0 1 80005004", ex_code, cp0_eret, cp0_mtc0, flush, ex_pc);
    end
    step();
    n_cmp++;
    if ({redirect_valid, redirect_pc} !== {1'b1, VEC}) begin
      n_fail++; $display("FAIL int_redirect: got rv=%b rpc=%h want 1 %h", redirect_valid, redirect_pc, VEC);
    end
    reset = 1;
    step();
    n_cmp++;
    if (act_o !== '0) begin n_fail++; $display("FAIL reset_in_redirect: got %h want 0", act_o); end
    reset = 0;
    step();
    n_cmp++;
    if (act_o !== '0) begin n_fail++; $display("FAIL after_reset_idle: got %h want 0", act_o); end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      wb_valid = ($urandom_range(0, 1) == 1);
      wb_pc = $urandom; wb_bd = 1'($urandom); wb_data_vaddr = $urandom;
      r = $urandom_range(0, 3);
      wb_ex_flags = (r == 0) ? 7'($urandom) : ((r == 1) ? 7'(1 << $urandom_range(0, 6)) : 7'h0);
      int_pending = ($urandom_range(0, 9) == 0);
      wb_eret = ($urandom_range(0, 4) == 0);
      wb_mtc0 = ($urandom_range(0, 2) == 0);
      wb_mtc0_addr = ($urandom_range(0, 1) == 1) ? 5'd14 : 5'($urandom);
      wb_mtc0_data = $urandom;
      redirect_ready = ($urandom_range(0, 2) != 0);
      step();
      n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++; $display("FAIL random_%0d: got %h want %h", n, act_o, exp_o);
      end
    end
    reset = 0;
    clear_in();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1;
    clear_in();
    test_reset();
    test_ov();
    test_adel_if();
    test_priority();
    test_mtc0_eret();
    test_stall();
    test_int_override();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
